// File: rtl/synth_env_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synth_env_pkg
// Description : Shared phase encoding and default widths for the per-voice
//               ADSR envelope sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package synth_env_pkg;

    localparam int ENV_DATA_W    = 20;
    localparam int ENV_SHIFT_W   = 5;
    localparam int ENV_RATE_W    = 16;
    localparam int ENV_MAX_SHIFT = 20;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_phase_e;

endpackage
`default_nettype wire

// File: rtl/env_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : env_step_timer
// Description : Step-rate divider. Fires one step every rate+1 enabled
//               cycles; cleared whenever the envelope changes phase.
// Revision    : 1.0 - initial release
// ============================================================================
module env_step_timer #(
    parameter int RATE_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [RATE_W-1:0] rate,
    output logic              step
);

    logic [RATE_W-1:0] cnt;

    // Step fires on the cycle the count reaches the live rate setting.
    assign step = enable && (cnt == rate);

    // Counter: restarts on clear or on a step, otherwise counts while enabled.
    // If rate drops below cnt mid-phase the counter simply wraps.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == rate) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + RATE_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/envelope_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : envelope_sequencer
// Description : Per-voice ADSR controller. Sequences a saturating attenuation
//               shift through IDLE/ATTACK/DECAY/SUSTAIN/RELEASE from the note
//               gate and applies it to the voice sample as a right shift.
// Revision    : 1.0 - initial release
// ============================================================================
module envelope_sequencer
    import synth_env_pkg::*;
#(
    parameter int DATA_W    = ENV_DATA_W,
    parameter int SHIFT_W   = ENV_SHIFT_W,
    parameter int RATE_W    = ENV_RATE_W,
    parameter int MAX_SHIFT = ENV_MAX_SHIFT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               note_on,
    input  logic [RATE_W-1:0]  attack_rate,
    input  logic [RATE_W-1:0]  decay_rate,
    input  logic [RATE_W-1:0]  release_rate,
    input  logic [SHIFT_W-1:0] sustain_shift,
    input  logic [DATA_W-1:0]  sample_in,
    output logic [DATA_W-1:0]  sample_out,
    output logic [SHIFT_W-1:0] shift_amount,
    output logic [2:0]         phase,
    output logic               start_decay,
    output logic               active
);

    localparam logic [SHIFT_W-1:0] C_MAX = SHIFT_W'(MAX_SHIFT);

    env_phase_e         state, state_next;
    logic [SHIFT_W-1:0] shift_next;
    logic               start_decay_next;
    logic               note_prev;
    logic               rise, fall;
    logic [SHIFT_W-1:0] sustain_clamped;
    logic [RATE_W-1:0]  rate_sel;
    logic               timer_enable, timer_clear, step;

    assign rise            = note_on & ~note_prev;
    assign fall            = ~note_on & note_prev;
    assign sustain_clamped = (sustain_shift > C_MAX) ? C_MAX : sustain_shift;
    assign timer_enable    = (state == ATTACK) || (state == DECAY) || (state == RELEASE);
    assign timer_clear     = (state_next != state);
    assign phase           = state;
    assign active          = (state != IDLE);

    // Step rate follows the current phase; rates are sampled live.
    always_comb begin
        rate_sel = '0;
        case (state)
            ATTACK:  rate_sel = attack_rate;
            DECAY:   rate_sel = decay_rate;
            RELEASE: rate_sel = release_rate;
            default: rate_sel = '0;
        endcase
    end

    env_step_timer #(
        .RATE_W (RATE_W)
    ) u_step_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .rate   (rate_sel),
        .step   (step)
    );

    // Next-state and next-shift: gate rise beats gate fall beats per-phase logic.
    always_comb begin
        state_next       = state;
        shift_next       = shift_amount;
        start_decay_next = 1'b0;
        if (rise) begin
            // Retrigger keeps the current level to avoid a click.
            state_next = ATTACK;
        end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
            state_next = RELEASE;
        end else begin
            case (state)
                IDLE: begin
                    shift_next = C_MAX;
                end
                ATTACK: begin
                    if (shift_amount == '0) begin
                        state_next       = DECAY;
                        start_decay_next = 1'b1;
                    end else if (step) begin
                        shift_next = shift_amount - SHIFT_W'(1);
                    end
                end
                DECAY: begin
                    if (shift_amount >= sustain_clamped) begin
                        state_next = SUSTAIN;
                    end else if (step) begin
                        shift_next = shift_amount + SHIFT_W'(1);
                    end
                end
                SUSTAIN: begin
                    shift_next = shift_amount;
                end
                RELEASE: begin
                    if (shift_amount == C_MAX) begin
                        state_next = IDLE;
                    end else if (step) begin
                        shift_next = shift_amount + SHIFT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    shift_next = C_MAX;
                end
            endcase
        end
    end

    // State, shift, gate history and the attenuated sample register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            shift_amount <= C_MAX;
            start_decay  <= 1'b0;
            note_prev    <= 1'b0;
            sample_out   <= '0;
        end else begin
            state        <= state_next;
            shift_amount <= shift_next;
            start_decay  <= start_decay_next;
            note_prev    <= note_on;
            sample_out   <= sample_in >> shift_amount;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_envelope_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_envelope_sequencer
// Description : Directed self-checking bench for envelope_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_envelope_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        note_on;
    logic [15:0] attack_rate, decay_rate, release_rate;
    logic [4:0]  sustain_shift;
    logic [19:0] sample_in;
    logic [19:0] sample_out;
    logic [4:0]  shift_amount;
    logic [2:0]  phase;
    logic        start_decay;
    logic        active;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [2:0] P_IDLE = 3'd0, P_ATT = 3'd1, P_DEC = 3'd2,
                           P_SUS  = 3'd3, P_REL = 3'd4;

    always #5 clk = ~clk;

    envelope_sequencer #(
        .DATA_W    (20),
        .SHIFT_W   (5),
        .RATE_W    (16),
        .MAX_SHIFT (20)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .note_on       (note_on),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .release_rate  (release_rate),
        .sustain_shift (sustain_shift),
        .sample_in     (sample_in),
        .sample_out    (sample_out),
        .shift_amount  (shift_amount),
        .phase         (phase),
        .start_decay   (start_decay),
        .active        (active)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        note_on       = 1'b1;
        attack_rate   = 16'd0;
        decay_rate    = 16'd1;
        release_rate  = 16'd0;
        sustain_shift = 5'd4;
        sample_in     = 20'hFFFFF;

        // Reset held with gate high
        tick();
        tick();
        chk("rst_shift", 32'(shift_amount), 32'd20);
        chk("rst_sample", 32'(sample_out), 32'd0);
        chk("rst_phase", 32'(phase), 32'(P_IDLE));
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_start", 32'(start_decay), 32'd0);

        // Gate held through reset appears as a rise
        reset = 1'b0;
        tick();
        chk("rise_phase", 32'(phase), 32'(P_ATT));
        chk("rise_shift", 32'(shift_amount), 32'd20);
        chk("rise_active", 32'(active), 32'd1);

        // Attack at rate 0: one step per cycle down to 0
        for (int k = 19; k >= 0; k--) begin
            tick();
            chk("att_shift", 32'(shift_amount), 32'(k));
            chk("att_nostart", 32'(start_decay), 32'd0);
        end
        chk("att_phase", 32'(phase), 32'(P_ATT));
        tick();
        chk("dec_phase", 32'(phase), 32'(P_DEC));
        chk("dec_start", 32'(start_decay), 32'd1);
        chk("dec_shift0", 32'(shift_amount), 32'd0);

        // Decay at rate 1: one step every two cycles up to 4
        begin
            int exp_d [8] = '{0, 1, 1, 2, 2, 3, 3, 4};
            for (int k = 0; k < 8; k++) begin
                tick();
                chk("dec_shift", 32'(shift_amount), 32'(exp_d[k]));
                chk("dec_hold", 32'(phase), 32'(P_DEC));
                chk("dec_pulse1", 32'(start_decay), 32'd0);
            end
        end
        tick();
        chk("sus_phase", 32'(phase), 32'(P_SUS));
        chk("sus_shift", 32'(shift_amount), 32'd4);
        chk("sus_sample", 32'(sample_out), 32'h0FFFF);

        // Sustain ignores later sustain_shift changes
        sustain_shift = 5'd10;
        tick();
        tick();
        chk("sus_ignore_phase", 32'(phase), 32'(P_SUS));
        chk("sus_ignore_shift", 32'(shift_amount), 32'd4);
        sample_in = 20'h12345;
        tick();
        chk("sus_sample2", 32'(sample_out), 32'h01234);

        // Release at rate 0 from 4 to 20, then idle
        note_on = 1'b0;
        tick();
        chk("rel_phase", 32'(phase), 32'(P_REL));
        chk("rel_shift4", 32'(shift_amount), 32'd4);
        for (int k = 5; k <= 20; k++) begin
            tick();
            chk("rel_shift", 32'(shift_amount), 32'(k));
        end
        chk("rel_phase_end", 32'(phase), 32'(P_REL));
        tick();
        chk("idle_phase", 32'(phase), 32'(P_IDLE));
        chk("idle_active", 32'(active), 32'd0);
        chk("idle_shift", 32'(shift_amount), 32'd20);
        tick();
        chk("idle_sample", 32'(sample_out), 32'd0);

        // Retrigger from release at shift 12; sustain 31 clamps to 20
        sustain_shift = 5'd31;
        decay_rate    = 16'd0;
        note_on       = 1'b1;
        tick();
        chk("rt_att", 32'(phase), 32'(P_ATT));
        for (int k = 0; k < 16; k++) tick();
        chk("rt_att_shift4", 32'(shift_amount), 32'd4);
        note_on = 1'b0;
        tick();
        chk("rt_rel", 32'(phase), 32'(P_REL));
        chk("rt_rel_shift", 32'(shift_amount), 32'd4);
        for (int k = 0; k < 8; k++) tick();
        chk("rt_rel12", 32'(shift_amount), 32'd12);
        note_on = 1'b1;
        tick();
        chk("rt_phase", 32'(phase), 32'(P_ATT));
        chk("rt_shift", 32'(shift_amount), 32'd12);
        for (int k = 11; k >= 0; k--) begin
            tick();
            chk("rt_dn", 32'(shift_amount), 32'(k));
        end
        tick();
        chk("rt_dec", 32'(phase), 32'(P_DEC));
        chk("rt_start", 32'(start_decay), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("rt_up", 32'(shift_amount), 32'(k));
        end
        chk("rt_dec_end", 32'(phase), 32'(P_DEC));
        tick();
        chk("rt_sus", 32'(phase), 32'(P_SUS));
        chk("rt_sus_shift", 32'(shift_amount), 32'd20);
        tick();
        chk("rt_sus_clamp", 32'(shift_amount), 32'd20);

        // Reset mid-attack at shift 7
        note_on = 1'b0;
        tick();
        tick();
        chk("r6_idle", 32'(phase), 32'(P_IDLE));
        note_on = 1'b1;
        tick();
        for (int k = 0; k < 13; k++) tick();
        chk("r6_att7", 32'(shift_amount), 32'd7);
        chk("r6_attp", 32'(phase), 32'(P_ATT));
        reset = 1'b1;
        tick();
        chk("r6_phase", 32'(phase), 32'(P_IDLE));
        chk("r6_shift", 32'(shift_amount), 32'd20);
        chk("r6_sample", 32'(sample_out), 32'd0);
        chk("r6_start", 32'(start_decay), 32'd0);
        chk("r6_active", 32'(active), 32'd0);
        reset = 1'b0;
        tick();
        chk("r6_rise", 32'(phase), 32'(P_ATT));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/envelope_sequencer.md
Name: envelope_sequencer

Overview:
Per-voice ADSR controller for the shift-based amplitude scaler.
- Sequences a 5-bit attenuation shift through IDLE/ATTACK/DECAY/SUSTAIN/RELEASE from a note gate and per-phase rate settings.
- Applies the shift to the voice sample: sample_out = sample_in >> shift.
- Sits between the note/key logic and the voice mixer, and replaces free-running attack scaling with one owned state machine.

Parameters:
DATA_W, 20, sample width
SHIFT_W, 5, shift/attenuation width
RATE_W, 16, width of per-phase rate settings
MAX_SHIFT, 20, full-attenuation shift (output is 0 when shift = MAX_SHIFT); must be <= 2^SHIFT_W-1

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
note_on  in  1  note gate level (1 = key held)
attack_rate  in  RATE_W  cycles per attack step, minus 1
decay_rate  in  RATE_W  cycles per decay step, minus 1
release_rate  in  RATE_W  cycles per release step, minus 1
sustain_shift  in  SHIFT_W  sustain attenuation; values > MAX_SHIFT treated as MAX_SHIFT
sample_in  in  DATA_W  unsigned voice sample
sample_out  out  DATA_W  attenuated sample, registered
shift_amount  out  SHIFT_W  current attenuation shift, registered
phase  out  3  current state encoding
start_decay  out  1  one-cycle pulse on ATTACK->DECAY
active  out  1  high when phase != IDLE

Behaviour:
Interface
- Single clock clk. Reset is synchronous and active-high.
- Reset values: phase=IDLE, shift_amount=MAX_SHIFT, sample_out=0, start_decay=0, active=0, step counter=0, note_prev=0.
- Reset mid-operation aborts any phase and applies the reset values on the next edge.

Gate edges
- note_prev is a register of note_on. rise = note_on & ~note_prev; fall = ~note_on & note_prev.
- Because note_prev resets to 0, a gate held high through reset causes a rise on the first cycle after reset.

Step timer
- Counter cnt runs only in ATTACK, DECAY and RELEASE.
- When cnt == the active rate: cnt <= 0 and one step fires. Otherwise cnt++.
- A step therefore fires every rate+1 cycles; rate=0 steps every cycle.
- cnt clears on every phase change.

State transitions, evaluated in this priority order each cycle:
1. rise in any state: go to ATTACK. shift_amount is unchanged (retrigger starts from the current level, no click).
2. fall in ATTACK/DECAY/SUSTAIN: go to RELEASE from the current shift.
3. Otherwise, per state:
   - IDLE: hold shift_amount=MAX_SHIFT.
   - ATTACK: if shift_amount == 0, go to DECAY and assert start_decay for that one cycle. Else, on a step, shift_amount--.
   - DECAY: if shift_amount >= clamped sustain_shift, go to SUSTAIN. Else, on a step, shift_amount++.
   - SUSTAIN: hold shift_amount. Later sustain_shift changes are ignored until the next DECAY.
   - RELEASE: if shift_amount == MAX_SHIFT, go to IDLE. Else, on a step, shift_amount++.

Arithmetic and timing
- shift_amount never leaves [0, MAX_SHIFT]; saturate, no wrap.
- sample_out <= sample_in >> shift_amount, using the registered shift: one-cycle latency, logical shift, zero fill.
- Rates are sampled live each cycle. A rate change mid-phase takes effect on the next cnt comparison. If cnt > the new rate, cnt keeps incrementing and wraps before stepping; this is accepted and not an error.

Decomposition:
Shared package synth_env_pkg:
- Phase encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- Default widths DATA_W, SHIFT_W, RATE_W.

One sub-module, env_step_timer:
- Holds cnt; inputs clear, enable, rate; output step pulse.
- Instantiated once; its rate is muxed by phase.

The FSM, shift register and output scaler stay in the top module.

Test Plan:
1. reset=1 for 2 cycles with note_on=1 -> shift_amount=20, sample_out=0, phase=IDLE. After release, a rise is seen; phase=ATTACK next cycle.
2. attack_rate=0, gate held -> shift_amount steps 20,19,...,0 on consecutive cycles. Then phase=DECAY with exactly one start_decay pulse.
3. decay_rate=1, sustain_shift=4 after scenario 2 -> shift 0->4, one step every 2 cycles, then phase=SUSTAIN, held. sample_in=0xFFFFF -> sample_out=0x0FFFF one cycle later.
4. From SUSTAIN at 4, note_on falls with release_rate=0 -> RELEASE; shift steps 5..20 each cycle; then IDLE, active=0.
5. Retrigger: in RELEASE at shift=12, note_on rises -> ATTACK next cycle with shift=12, decrementing to 0. sustain_shift=31 clamps to 20, so DECAY ends with SUSTAIN at 20.
6. Reset asserted mid-ATTACK at shift=7 -> next edge: IDLE, shift=20, sample_out=0, no start_decay pulse.
